ysyx_23060042_ifu: RTL and testbench
====================================

# ysyx_23060042_ifu

Instruction fetch unit of the NPC core. Holds the architectural PC, issues one 32-bit read per instruction on the instruction-memory request/response interface, and hands the fetched word plus its PC to the decode stage through a valid/ready handshake. Accepts a redirect (branch/jump/trap target) from the execute stage and discards any in-flight or held instruction on the old path. Strictly one outstanding fetch; no prediction.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req_valid  output  1  fetch request present.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  fetch address, always equals current PC.
- imem_rsp_valid  input  1  read data returned.
- imem_rsp_data  input  32  instruction word.
- inst_valid  output  1  held instruction available to decode.
- inst_ready  input  1  decode consumes held instruction.
- inst  output  32  registered instruction word.
- inst_pc  output  32  PC of inst.
- redirect_valid  input  1  execute-stage PC override.
- redirect_pc  input  32  new PC; bits [1:0] ignored (forced to 0).

## Operation
- State machine: REQ, WAIT, HOLD. Reset state REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: if kill flag clear, capture imem_rsp_data into inst and pc into inst_pc -> HOLD; if kill set, drop data, clear kill -> REQ.
- HOLD: inst_valid=1. On inst_valid&&inst_ready: pc<=pc+32'd4 -> REQ.
- Redirect (any state) loads pc<={redirect_pc[31:2],2'b00}, priority over +4:
  - REQ without req_ready: stay REQ, next request uses new pc.
  - REQ with req_ready same cycle: old address already accepted -> WAIT with kill set.
  - WAIT: set kill; stay WAIT until the response arrives (response with redirect same cycle: data dropped, -> REQ, kill stays clear).
  - HOLD: drop held instruction (inst_valid falls next cycle) -> REQ, whether or not inst_ready is high that cycle.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Only one request outstanding; imem_req_valid never asserted in WAIT or HOLD.

## Timing
- Reset values: pc=RESET_PC, state=REQ, kill=0, inst_valid=0, inst=32'h0, inst_pc=RESET_PC; imem_req_valid=0 while rst high.
- imem_req_valid is combinational from state (1 in REQ, rst low); stable until accepted.
- Memory responds no earlier than the cycle after acceptance.
- Best case: accept cycle N, response N+1, inst_valid N+2; consumed at N+2 gives next request at N+3 (3-cycle per-instruction throughput).
- inst and inst_pc stable while inst_valid=1 and not consumed.
- rst mid-WAIT: state returns to REQ; the late response is ignored because it only matters in WAIT—memory must be reset in the same cycle.

## Configuration
- YSYX_23060042_IFU_PERF_EN defined: adds outputs perf_fetch_cnt (64-bit, increments on each non-killed response captured) and perf_stall_cnt (64-bit, increments each cycle in REQ with imem_req_ready=0 or in WAIT); both reset to 0.
- Undefined: ports and counters absent; fetch behaviour identical.

## Test plan
- Reset release, memory always ready, 1-cycle response, inst_ready=1: requests at 0x80000000, 0x80000004, 0x80000008; inst_pc matches, inst equals returned words.
- Decode back-pressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc unchanged, no new request; next request after handshake at pc+4.
- Redirect in HOLD to 0x80001002 -> held inst dropped, next request address 0x80001000.
- Redirect in same cycle as req accept at 0x80000004 to 0x80000100 -> response for 0x80000004 discarded (inst_valid stays 0), next request 0x80000100.
- Redirect to 0xFFFFFFFC, consume -> next request 0x00000000.
- With YSYX_23060042_IFU_PERF_EN: imem_req_ready=0 for 3 cycles then 2-cycle response latency -> perf_stall_cnt=5, perf_fetch_cnt=1.

Source files
------------

// File: rtl/ysyx_23060042_ifu.sv
// Instruction fetch unit: holds the PC, issues one imem read at a time, and hands inst/pc to decode.
// Optional perf counters are enabled with `define YSYX_23060042_IFU_PERF_EN.
module ysyx_23060042_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef YSYX_23060042_IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic        r_kill;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] w_redir_pc;

    assign w_redir_pc     = {redirect_pc[31:2], 2'b00};
    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_kill    <= 1'b0;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_inst_pc <= RESET_PC;
        end else begin
            // A redirect always wins the PC; the state case only decides what happens to the fetch.
            if (redirect_valid) r_pc <= w_redir_pc;
            case (r_state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                        r_kill  <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_kill || redirect_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst    <= imem_rsp_data;
                            r_inst_pc <= r_pc;
                            r_state   <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_state <= S_REQ;
                    end else if (inst_ready) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

`ifdef YSYX_23060042_IFU_PERF_EN
    logic [63:0] r_fetch_cnt;
    logic [63:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 64'd0;
            r_stall_cnt <= 64'd0;
        end else begin
            if (r_state == S_WAIT && imem_rsp_valid && !r_kill && !redirect_valid)
                r_fetch_cnt <= r_fetch_cnt + 64'd1;
            if ((r_state == S_REQ && !imem_req_ready) || r_state == S_WAIT)
                r_stall_cnt <= r_stall_cnt + 64'd1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ysyx_23060042_ifu.sv
// Directed bench for ysyx_23060042_ifu: table-driven fetch stream plus redirect/reset corner sequences.
module tb_ysyx_23060042_ifu;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef YSYX_23060042_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ysyx_23060042_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef YSYX_23060042_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic mem_auto = 1'b1;

    typedef struct {
        int          stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; memory model answers one cycle after each accepted request.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_rsp_valid = acc;
            imem_rsp_data  = acc ? (a ^ KEY) : 32'h0;
        end
    endtask

    task automatic wait_inst(input string name, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!inst_valid && lat < 20);
        if (!inst_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: inst_valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        int lat;
        vt[0] = '{0, 32'h8000_0000, 32'h9357_9BDF};
        vt[1] = '{0, 32'h8000_0004, 32'h9357_9BDB};
        vt[2] = '{5, 32'h8000_0008, 32'h9357_9BD7};
        vt[3] = '{0, 32'h8000_000C, 32'h9357_9BD3};

        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h8000_0000);
        chk("rst_addr", imem_req_addr, 32'h8000_0000);
        rst = 1'b0;
        #1;
        chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);

        // Sequential fetch stream with best-case memory, one entry under decode back-pressure.
        for (int i = 0; i < 4; i++) begin
            chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("req_addr", imem_req_addr, vt[i].exp_addr);
            wait_inst("fetch", lat);
            chk("latency", lat, 32'd2);
            chk("inst", inst, vt[i].exp_inst);
            chk("inst_pc", inst_pc, vt[i].exp_addr);
            for (int s = 0; s < vt[i].stall; s++) begin
                tick();
                chk("bp_valids", {30'd0, inst_valid, imem_req_valid}, 32'd2);
                chk("bp_inst", inst, vt[i].exp_inst);
                chk("bp_inst_pc", inst_pc, vt[i].exp_addr);
            end
            consume();
        end

        // Redirect while holding: held inst dropped even with inst_ready high.
        chk("pre_hold_addr", imem_req_addr, 32'h8000_0010);
        wait_inst("hold_redir", lat);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1002;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        chk("hold_redir_valids", {30'd0, inst_valid, imem_req_valid}, 32'd1);
        chk("hold_redir_addr", imem_req_addr, 32'h8000_1000);

        // Redirect in the same cycle the request is accepted: response must be discarded.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("kill_wait_valids", {30'd0, inst_valid, imem_req_valid}, 32'd0);
        tick();
        chk("kill_drop_valids", {30'd0, inst_valid, imem_req_valid}, 32'd1);
        chk("kill_next_addr", imem_req_addr, 32'h8000_0100);
        wait_inst("post_kill", lat);
        chk("post_kill_inst", inst, 32'h9357_9ADF);
        chk("post_kill_pc", inst_pc, 32'h8000_0100);
        consume();

        // Redirect during WAIT with a slow memory: stays in WAIT until the late response, then drops it.
        mem_auto = 1'b0;
        chk("slow_addr", imem_req_addr, 32'h8000_0104);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0203;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wait_kill_valids", {30'd0, inst_valid, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("wait_drop_valids", {30'd0, inst_valid, imem_req_valid}, 32'd1);
        chk("wait_drop_addr", imem_req_addr, 32'h8000_0200);
        mem_auto = 1'b1;

        // Redirect in REQ without ready, to the top of the address space, then wrap on consume.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("req_redir_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        wait_inst("top_fetch", lat);
        chk("top_inst", inst, 32'hECA8_6423);
        chk("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
        consume();
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);

        // Reset in the middle of WAIT returns to REQ at RESET_PC with nothing held.
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_valids", {30'd0, inst_valid, imem_req_valid}, 32'd1);
        chk("midrst_addr", imem_req_addr, 32'h8000_0000);
        chk("midrst_inst", inst, 32'h0);

`ifdef YSYX_23060042_IFU_PERF_EN
        chk("perf_rst_fetch", perf_fetch_cnt[31:0], 32'd0);
        chk("perf_rst_stall", perf_stall_cnt[31:0], 32'd0);
        mem_auto = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        tick();
        tick();
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("perf_inst", inst, 32'h0000_0013);
        chk("perf_stall", perf_stall_cnt[31:0], 32'd5);
        chk("perf_fetch", perf_fetch_cnt[31:0], 32'd1);
        mem_auto = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
